// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter: default pointer width,
// the queued write request record, and the one-hot decode used for busy masks.
package wb_pkg;

    localparam int WB_PW   = 4;
    localparam int WB_NREG = 2 ** WB_PW;

    typedef struct packed {
        logic [WB_PW-1:0] addr;
        logic [7:0]       dat;
    } wb_req_t;

    function automatic logic [WB_NREG-1:0] onehot(input logic [WB_PW-1:0] a);
        logic [WB_NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order deferral FIFO for ALU results that lose the write port; exposes
// per-entry valid/address so the parent can build the pending-write mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wb_req_t                i_push_req,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic [CW-1:0]          o_count,
    output logic [DEPTH-1:0]       o_ent_vld,
    output logic [DEPTH*WB_PW-1:0] o_ent_addr
);

    wb_req_t       r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Payload storage carries no reset; validity comes from pointers and count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] w_off;
        assign w_off                         = AW'(i) - r_rptr;
        assign o_ent_vld[i]                  = (CW'(w_off) < r_count);
        assign o_ent_addr[i*WB_PW +: WB_PW]  = r_mem[i].addr;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: load returns own the register-file write port, colliding
// ALU results wait in a FIFO, and a busy mask reports every pending destination.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int PW    = WB_PW,
    parameter  int DEPTH = 4,
    localparam int NREG  = 2 ** PW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [PW-1:0]   alu_addr,
    input  logic [7:0]      alu_dat,
    output logic            alu_ready,
    input  logic            ld_issue,
    input  logic [PW-1:0]   ld_addr,
    input  logic [7:0]      mem_dat,
    output logic            wr_en,
    output logic [PW:0]     wr_addr,
    output logic [7:0]      wb_dat,
    output logic [NREG-1:0] busy_mask,
    output logic            err
);

    logic          r_ld_pend;
    logic [PW-1:0] r_ld_dst;
    logic          r_wr_en;
    logic [PW-1:0] r_wr_addr;
    logic [7:0]    r_wb_dat;
    logic          r_err;

    logic                   w_alu_ready;
    logic                   w_alu_acc;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_sel_vld;
    wb_req_t                w_sel;
    wb_req_t                w_alu_req;
    wb_req_t                w_head;
    logic [CW-1:0]          w_count;
    logic [DEPTH-1:0]       w_ent_vld;
    logic [DEPTH*PW-1:0]    w_ent_addr;
    logic [NREG-1:0]        w_busy;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_req (w_alu_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_ent_vld  (w_ent_vld),
        .o_ent_addr (w_ent_addr)
    );

    // Ready is held low through reset so nothing is accepted into a clearing FIFO.
    assign w_alu_ready  = !reset && (w_count < CW'(DEPTH));
    assign w_alu_acc    = alu_valid && w_alu_ready;
    assign w_fifo_empty = (w_count == '0);
    assign w_alu_req    = '{addr: alu_addr, dat: alu_dat};

    // Priority: load return, then FIFO head, then direct ALU bypass.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_sel_vld = 1'b0;
        w_sel     = w_head;
        if (r_ld_pend) begin
            w_sel_vld = 1'b1;
            w_sel     = '{addr: r_ld_dst, dat: mem_dat};
            w_push    = w_alu_acc;
        end else if (!w_fifo_empty) begin
            w_sel_vld = 1'b1;
            w_sel     = w_head;
            w_pop     = 1'b1;
            w_push    = w_alu_acc;
        end else if (w_alu_acc) begin
            w_sel_vld = 1'b1;
            w_sel     = w_alu_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_pend <= 1'b0;
            r_ld_dst  <= '0;
        end else begin
            r_ld_pend <= ld_issue;
            r_ld_dst  <= ld_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wb_dat  <= '0;
        end else begin
            r_wr_en <= w_sel_vld;
            if (w_sel_vld) begin
                r_wr_addr <= w_sel.addr;
                r_wb_dat  <= w_sel.dat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (alu_valid && !w_alu_ready) begin
            r_err <= 1'b1;
        end
    end

    always_comb begin
        w_busy = '0;
        if (r_ld_pend) begin
            w_busy = w_busy | onehot(r_ld_dst);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i]) begin
                w_busy = w_busy | onehot(w_ent_addr[i*PW +: PW]);
            end
        end
        if (r_wr_en) begin
            w_busy = w_busy | onehot(r_wr_addr);
        end
    end

    assign alu_ready = w_alu_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = {1'b0, r_wr_addr};
    assign wb_dat    = r_wb_dat;
    assign busy_mask = w_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes (cycle, address, data) are
// queued as stimulus is issued and a negedge monitor matches every wr_en.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_addr = '0;
    logic [7:0]  alu_dat = '0;
    logic        alu_ready;
    logic        ld_issue = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [7:0]  mem_dat = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wb_dat;
    logic [15:0] busy_mask;
    logic        err;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    wb_arbiter #(.PW(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_dat   (alu_dat),
        .alu_ready (alu_ready),
        .ld_issue  (ld_issue),
        .ld_addr   (ld_addr),
        .mem_dat   (mem_dat),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wb_dat    (wb_dat),
        .busy_mask (busy_mask),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_wr(input int c, input int a, input int d);
        exp_t e;
        e.cyc  = c;
        e.addr = 5'(a);
        e.dat  = 8'(d);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor plus the upstream hazard rule.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_write cyc=%0d want_cyc=%0d want_addr=%0d want_dat=%h",
                     cyc, sb[0].cyc, sb[0].addr, sb[0].dat);
            void'(sb.pop_front());
        end
        if (wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got_addr=%0d got_dat=%h", cyc, wr_addr, wb_dat);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.addr !== wr_addr || e.dat !== wb_dat) begin
                    errors++;
                    $display("FAIL write cyc=%0d got_addr=%0d got_dat=%h want_cyc=%0d want_addr=%0d want_dat=%h",
                             cyc, wr_addr, wb_dat, e.cyc, e.addr, e.dat);
                end
            end
        end
        if (alu_valid) begin
            checks++;
            if (busy_mask[alu_addr]) begin
                errors++;
                $display("FAIL alu_hazard cyc=%0d addr=%0d mask=%h", cyc, alu_addr, busy_mask);
            end
        end
        if (ld_issue) begin
            checks++;
            if (busy_mask[ld_addr]) begin
                errors++;
                $display("FAIL ld_hazard cyc=%0d addr=%0d mask=%h", cyc, ld_addr, busy_mask);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wb_dat", 32'(wb_dat), 0);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_ready", 32'(alu_ready), 0);
        chk("rst_err", 32'(err), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(alu_ready), 1);

        // ALU bypass
        next_cycle();
        c = cyc;
        alu_valid = 1'b1; alu_addr = 4'd3; alu_dat = 8'h5A;
        exp_wr(c + 1, 3, 'h5A);
        @(negedge clk);
        chk("alu_busy_n", 32'(busy_mask), 0);
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_busy_n1", 32'(busy_mask), 32'h0008);
        next_cycle();
        @(negedge clk);
        chk("alu_busy_n2", 32'(busy_mask), 0);

        // Load only
        next_cycle();
        c = cyc;
        ld_issue = 1'b1; ld_addr = 4'd7;
        @(negedge clk);
        chk("ld_busy_n", 32'(busy_mask), 0);
        next_cycle();
        ld_issue = 1'b0; mem_dat = 8'hC3;
        exp_wr(c + 2, 7, 'hC3);
        @(negedge clk);
        chk("ld_busy_n1", 32'(busy_mask), 32'h0080);
        next_cycle();
        mem_dat = 8'h00;
        @(negedge clk);
        chk("ld_busy_n2", 32'(busy_mask), 32'h0080);
        next_cycle();
        @(negedge clk);
        chk("ld_busy_n3", 32'(busy_mask), 0);

        // Collision: load return wins, ALU deferred one cycle
        next_cycle();
        c = cyc;
        ld_issue = 1'b1; ld_addr = 4'd1;
        exp_wr(c + 2, 1, 'hAA);
        exp_wr(c + 3, 2, 'h11);
        @(negedge clk);
        next_cycle();
        ld_issue = 1'b0; mem_dat = 8'hAA;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_dat = 8'h11;
        @(negedge clk);
        chk("col_ready", 32'(alu_ready), 1);
        next_cycle();
        alu_valid = 1'b0; mem_dat = 8'h00;
        @(negedge clk);
        chk("col_busy_n2", 32'(busy_mask), 32'h0006);
        next_cycle();
        @(negedge clk);
        chk("col_busy_n3", 32'(busy_mask), 32'h0004);
        next_cycle();
        @(negedge clk);
        chk("col_busy_n4", 32'(busy_mask), 0);

        // Fill / full: six back-to-back loads with ALU pressure
        c = 0;
        for (int t = 0; t < 12; t++) begin
            next_cycle();
            if (t == 0) begin
                c = cyc;
                for (int i = 0; i < 6; i++) exp_wr(c + 2 + i, 8 + i, 'hB0 + i);
                for (int k = 0; k < 4; k++) exp_wr(c + 8 + k, k, 'h20 + k);
            end
            ld_issue  = (t <= 5);
            ld_addr   = 4'(8 + t);
            mem_dat   = (t >= 1 && t <= 6) ? 8'(8'hB0 + t - 1) : 8'h00;
            alu_valid = (t >= 1 && t <= 5);
            alu_addr  = 4'(t - 1);
            alu_dat   = 8'(8'h20 + t - 1);
            @(negedge clk);
            if (t == 4) chk("full_ready_3", 32'(alu_ready), 1);
            if (t == 5) chk("full_ready_4", 32'(alu_ready), 0);
            if (t == 5) chk("full_err_pre", 32'(err), 0);
            if (t == 6) chk("full_err_set", 32'(err), 1);
            if (t == 7) chk("full_busy", 32'(busy_mask), 32'h200F);
        end
        next_cycle();
        @(negedge clk);
        chk("drain_ready", 32'(alu_ready), 1);
        chk("drain_busy", 32'(busy_mask), 0);
        chk("drain_err_sticky", 32'(err), 1);

        // Reset mid-operation with two FIFO entries and a load in flight
        next_cycle();
        c = cyc;
        ld_issue = 1'b1; ld_addr = 4'd5;
        exp_wr(c + 2, 5, 'hD5);
        @(negedge clk);
        next_cycle();
        ld_addr = 4'd6; mem_dat = 8'hD5;
        alu_valid = 1'b1; alu_addr = 4'd9; alu_dat = 8'h77;
        @(negedge clk);
        next_cycle();
        ld_addr = 4'd7; mem_dat = 8'hD6;
        alu_addr = 4'd10; alu_dat = 8'h78;
        @(negedge clk);
        next_cycle();
        ld_issue = 1'b0; alu_valid = 1'b0; mem_dat = 8'h00;
        chk("mid_busy", 32'(busy_mask), 32'h06C0);
        chk("mid_wr_en", 32'(wr_en), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_busy", 32'(busy_mask), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_ready", 32'(alu_ready), 0);
        chk("arst_wr_addr", 32'(wr_addr), 0);
        chk("arst_wb_dat", 32'(wb_dat), 0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("arel_ready", 32'(alu_ready), 1);
        chk("arel_busy", 32'(busy_mask), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
        end
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the 16-entry register file's single write port. It merges ALU results and data-memory load returns into one registered write stream (`wr_en`/`wr_addr`/`wb_dat`). Load returns always win the port and ALU results that collide are held in a small in-order FIFO. It also exports a busy mask of registers with writes still pending, so decode can stall on hazards.

## Interface
- `PW`, 4, register address pointer width (2**PW registers)
- `DEPTH`, 4, ALU deferral FIFO entries (power of two, ≥2)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result offered this cycle
- `alu_addr`  in  PW  ALU destination register
- `alu_dat`  in  8  ALU result
- `alu_ready`  out  1  ALU result accepted when `alu_valid && alu_ready`
- `ld_issue`  in  1  load issued to data memory this cycle
- `ld_addr`  in  PW  load destination register
- `mem_dat`  in  8  data-memory read data, valid exactly 1 cycle after `ld_issue`
- `wr_en`  out  1  register-file write enable
- `wr_addr`  out  PW+1  register-file write address; bit PW always 0
- `wb_dat`  out  8  register-file write data
- `busy_mask`  out  2**PW  bit i set = write to register i pending
- `err`  out  1  sticky: ALU result offered while `alu_ready` low (result dropped)

Reset: one clock; reset is asynchronous and active-high (ports `clk`, `reset`).

## Operation
- Internal `ld_pend`/`ld_dst` register captures `ld_issue`/`ld_addr` each cycle. `ld_pend` high means a load return is present on `mem_dat` this cycle.
- Per cycle, the output register loads the first applicable source, in priority order:
  1. Load return (`ld_pend`): `{ld_dst, mem_dat}`.
  2. FIFO head: pop.
  3. Accepted ALU result, only when the FIFO is empty: direct bypass.
  4. Otherwise `wr_en` ← 0.
- An accepted ALU result not taken by the output register is pushed to the FIFO.
- Simultaneous push and pop in one cycle is allowed.
- `alu_ready` = !full (count < DEPTH), combinational from count. It is 0 while `reset` is asserted.
- Back-to-back `ld_issue` every cycle is legal. The FIFO then only fills, and drains once loads stop.
- `busy_mask`: OR of
  - one-hot(`ld_dst`) if `ld_pend`
  - one-hot(addr) for every valid FIFO entry
  - one-hot(`wr_addr`) if `wr_en`
- Upstream must not issue an ALU result or load whose destination bit is set in `busy_mask`. This guarantees per-register program order despite load priority. The bench asserts it; RTL does not check it.
- `err` sets on `alu_valid && !alu_ready` and clears only on reset. The dropped result is not written.

## Timing
- ALU bypass: `alu_valid` accepted in cycle N with empty FIFO and no load return → `wr_en` in N+1. The register file commits at the end of N+1.
- Load: `ld_issue` at N, `mem_dat` sampled at N+1, `wr_en` at N+2.
- A deferred ALU write lands k+1 cycles after the last load return, where k is its FIFO position (0 = head).
- `busy_mask` is combinational from registered state. A source accepted in cycle N appears in the mask from N+1 until its `wr_en` cycle inclusive.
- Reset (any time, including mid-load):
  - clears FIFO, count, `ld_pend`, `err`
  - outputs go to `wr_en`=0, `wr_addr`=0, `wb_dat`=0, `busy_mask`=0, `alu_ready`=0
  - in-flight load data is discarded
  - `alu_ready` returns to 1 the first cycle after deassertion.

## Structure
- Package `wb_pkg`:
  - `localparam` default PW
  - `typedef struct packed {logic[PW-1:0] addr; logic[7:0] dat;} wb_req_t`
  - one-hot helper function for mask generation
- Sub-module `wb_fifo`: parameterised DEPTH, `wb_req_t` entries.
  - Ports: push/pop, head out, count, per-entry valid + addr vector for `busy_mask`.
  - Wrap-around read/write pointers, count width $clog2(DEPTH)+1.
- Top holds the priority mux, load-pending register, output register and err flag.

## Test plan
- ALU only: `alu_valid` r3=8'h5A at cycle 2 → `wr_en`=1, `wr_addr`=3, `wb_dat`=8'h5A at cycle 3. `busy_mask`=16'h0008 in cycle 3 only.
- Load only: `ld_issue` r7 at cycle 2, `mem_dat`=8'hC3 at cycle 3 → write r7=8'hC3 at cycle 4. `busy_mask` bit 7 high in cycles 3–4.
- Collision: load r1 issued at N, ALU r2=8'h11 at N+1 → r1 written at N+2, r2 written at N+3. `busy_mask`=16'h0006 at N+2.
- Fill/full: loads every cycle for 6 cycles plus ALU every cycle → `alu_ready` drops after 4 accepts. The 5th `alu_valid` sets `err`. After loads stop, the 4 queued writes drain in order on 4 consecutive cycles.
- Reset mid-operation: 2 FIFO entries and `ld_pend` set, assert `reset` asynchronously mid-cycle → `wr_en`, `busy_mask`, `err` = 0 immediately. No writes after release. `alu_ready`=1 the cycle after release.
